// File: rtl/core_mem_stage.sv
// core_mem_stage
//
// Memory stage of the core pipeline, sitting between execute (M side) and
// writeback (W side). Loads and stores go out on a request/grant/response
// bus with a single access outstanding. Load data is lane-aligned and
// sign/zero-extended before it is registered into the W payload. A HOLD
// state keeps a returned response safe while writeback is stalled.
//
// Optional feature macro: CORE_MEM_MISALIGN_TRAP_EN
//   defined   : misaligned accesses skip the bus and reach W with w_exc = 1
//   undefined : no alignment check, bytemask is truncated to the word
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   m_valid / m_ready          M-stage payload handshake
//   m_pc .. m_mem_type         M-stage payload (address, store data, control)
//   bus_req/we/addr/wdata/bytemask, bus_gnt   request channel
//   bus_rvalid / bus_rdata     response channel (load data or store ack)
//   w_valid / w_ready          W-stage payload handshake
//   w_pc .. w_mem_rdata, w_exc registered W payload
module core_mem_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m_valid,
  output logic              m_ready,
  input  logic [XLEN-1:0]   m_pc,
  input  logic [XLEN-1:0]   m_pc4,
  input  logic [XLEN-1:0]   m_imm,
  input  logic [XLEN-1:0]   m_alu_out,
  input  logic [XLEN-1:0]   m_csr_value,
  input  logic [XLEN-1:0]   m_alu_sum,
  input  logic [XLEN-1:0]   m_rs2,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_reg_wen,
  input  logic [1:0]        m_reg_wsel,
  input  logic              m_mem_ren,
  input  logic              m_mem_wen,
  input  logic [2:0]        m_mem_type,

  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_bytemask,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata,

  output logic              w_valid,
  input  logic              w_ready,
  output logic [XLEN-1:0]   w_pc,
  output logic [XLEN-1:0]   w_pc4,
  output logic [XLEN-1:0]   w_imm,
  output logic [REG_AW-1:0] w_rd,
  output logic              w_reg_wen,
  output logic [1:0]        w_reg_wsel,
  output logic [XLEN-1:0]   w_alu_out,
  output logic [XLEN-1:0]   w_alu_sum,
  output logic [XLEN-1:0]   w_csr_value,
  output logic [2:0]        w_mem_type,
  output logic [XLEN-1:0]   w_mem_rdata,
  output logic              w_exc
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int MW    = 2 * NB;
  localparam int SHW   = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t state, state_next;

  logic [OFF_W-1:0] offset;
  logic [3:0]       size_bytes;
  logic [MW-1:0]    mask_wide;
  logic [MW-1:0]    mask_shifted;
  logic             is_mem;
  logic             is_load;
  logic             misalign;
  logic             mem_access;
  logic             can_load;
  logic             load_w;
  logic             capture;
  logic [XLEN-1:0]  rdata_hold;
  logic [XLEN-1:0]  load_ext;
  logic [XLEN-1:0]  w_rdata_next;

  assign offset   = m_alu_sum[OFF_W-1:0];
  assign is_mem   = m_mem_ren | m_mem_wen;
  // A request with both enables set behaves as a store.
  assign is_load  = m_mem_ren & ~m_mem_wen;
  assign can_load = ~w_valid | w_ready;

  always_comb begin
    case (m_mem_type[1:0])
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  end

`ifdef CORE_MEM_MISALIGN_TRAP_EN
  assign misalign = is_mem && ((4'(offset) & (size_bytes - 4'd1)) != 4'd0);
`else
  assign misalign = 1'b0;
`endif

  assign mem_access = is_mem & ~misalign;

  // The mask is built twice as wide as the word so that lanes pushed past
  // the top by a misaligned offset simply fall off when truncated.
  assign mask_wide    = (MW'(1) << size_bytes) - MW'(1);
  assign mask_shifted = mask_wide << offset;
  assign bus_bytemask = mask_shifted[NB-1:0];

  assign bus_addr  = {m_alu_sum[XLEN-1:OFF_W], OFF_W'(0)};
  assign bus_wdata = m_rs2 << {offset, 3'b000};
  assign bus_we    = bus_req & m_mem_wen;

  // Load alignment and extension. M holds stable for the whole access, so
  // the offset and type are taken straight from the M payload even when the
  // data comes from the holding register. Extension is a left shift that
  // parks the loaded field at the top, then a logical or arithmetic shift
  // back down.
  always_comb begin
    logic [XLEN-1:0]        raw;
    logic [XLEN-1:0]        shifted;
    logic [XLEN-1:0]        left;
    logic signed [XLEN-1:0] left_s;
    logic signed [XLEN-1:0] sext;
    logic [XLEN-1:0]        zext;
    logic [SHW-1:0]         ext_shamt;

    raw     = (state == S_HOLD) ? rdata_hold : bus_rdata;
    shifted = raw >> {offset, 3'b000};
    case (m_mem_type[1:0])
      2'b00:   ext_shamt = SHW'(XLEN - 8);
      2'b01:   ext_shamt = SHW'(XLEN - 16);
      2'b10:   ext_shamt = SHW'(XLEN - 32);
      default: ext_shamt = '0;
    endcase
    left     = shifted << ext_shamt;
    left_s   = left;
    sext     = left_s >>> ext_shamt;
    zext     = left >> ext_shamt;
    load_ext = m_mem_type[2] ? zext : $unsigned(sext);
  end

  assign w_rdata_next = (is_load && mem_access) ? load_ext : '0;

  // State register; a reset mid-access simply abandons it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs. Non-memory ops (and trapped
  // misaligned ones) pass through in one cycle; memory ops wait for the
  // response and, if W is stalled, park it in HOLD.
  always_comb begin
    state_next = state;
    bus_req    = 1'b0;
    m_ready    = 1'b0;
    load_w     = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (m_valid) begin
          if (mem_access) begin
            bus_req = 1'b1;
            if (bus_gnt) begin
              state_next = S_WAIT;
            end
          end else begin
            m_ready = can_load;
            load_w  = can_load;
          end
        end
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          if (can_load) begin
            load_w     = 1'b1;
            m_ready    = 1'b1;
            state_next = S_IDLE;
          end else begin
            capture    = 1'b1;
            state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (can_load) begin
          load_w     = 1'b1;
          m_ready    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Raw response captured while writeback is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_hold <= '0;
    end else if (capture) begin
      rdata_hold <= bus_rdata;
    end
  end

  // W valid: set on a load, otherwise dropped once W has been accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid <= 1'b0;
    end else if (load_w) begin
      w_valid <= 1'b1;
    end else if (w_ready) begin
      w_valid <= 1'b0;
    end
  end

`ifdef CORE_MEM_MISALIGN_TRAP_EN
  logic w_exc_q;
  assign w_exc = w_exc_q;
`else
  assign w_exc = 1'b0;
`endif

  // W payload registers. A trapped access must not write the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_pc        <= '0;
      w_pc4       <= '0;
      w_imm       <= '0;
      w_rd        <= '0;
      w_reg_wen   <= 1'b0;
      w_reg_wsel  <= '0;
      w_alu_out   <= '0;
      w_alu_sum   <= '0;
      w_csr_value <= '0;
      w_mem_type  <= '0;
      w_mem_rdata <= '0;
`ifdef CORE_MEM_MISALIGN_TRAP_EN
      w_exc_q     <= 1'b0;
`endif
    end else if (load_w) begin
      w_pc        <= m_pc;
      w_pc4       <= m_pc4;
      w_imm       <= m_imm;
      w_rd        <= m_rd;
      w_reg_wen   <= m_reg_wen & ~misalign;
      w_reg_wsel  <= m_reg_wsel;
      w_alu_out   <= m_alu_out;
      w_alu_sum   <= m_alu_sum;
      w_csr_value <= m_csr_value;
      w_mem_type  <= m_mem_type;
      w_mem_rdata <= w_rdata_next;
`ifdef CORE_MEM_MISALIGN_TRAP_EN
      w_exc_q     <= misalign;
`endif
    end
  end

endmodule

// File: tb/tb_core_mem_stage.sv
// tb_core_mem_stage
//
// Bench for core_mem_stage at XLEN = 32. Each scenario task drives the M
// side and bus, pushes the W payload it expects onto a scoreboard queue,
// and pops and compares when W presents a payload. Inputs change on the
// falling edge; outputs are sampled 1 time unit later.
module tb_core_mem_stage;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk;
  logic              rst_n;
  logic              m_valid;
  logic              m_ready;
  logic [XLEN-1:0]   m_pc, m_pc4, m_imm, m_alu_out, m_csr_value, m_alu_sum, m_rs2;
  logic [REG_AW-1:0] m_rd;
  logic              m_reg_wen;
  logic [1:0]        m_reg_wsel;
  logic              m_mem_ren, m_mem_wen;
  logic [2:0]        m_mem_type;
  logic              bus_req, bus_we;
  logic [XLEN-1:0]   bus_addr, bus_wdata;
  logic [XLEN/8-1:0] bus_bytemask;
  logic              bus_gnt, bus_rvalid;
  logic [XLEN-1:0]   bus_rdata;
  logic              w_valid, w_ready;
  logic [XLEN-1:0]   w_pc, w_pc4, w_imm, w_alu_out, w_alu_sum, w_csr_value, w_mem_rdata;
  logic [REG_AW-1:0] w_rd;
  logic              w_reg_wen;
  logic [1:0]        w_reg_wsel;
  logic [2:0]        w_mem_type;
  logic              w_exc;

  core_mem_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_pc(m_pc), .m_pc4(m_pc4), .m_imm(m_imm), .m_alu_out(m_alu_out),
    .m_csr_value(m_csr_value), .m_alu_sum(m_alu_sum), .m_rs2(m_rs2),
    .m_rd(m_rd), .m_reg_wen(m_reg_wen), .m_reg_wsel(m_reg_wsel),
    .m_mem_ren(m_mem_ren), .m_mem_wen(m_mem_wen), .m_mem_type(m_mem_type),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_bytemask(bus_bytemask),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .w_valid(w_valid), .w_ready(w_ready),
    .w_pc(w_pc), .w_pc4(w_pc4), .w_imm(w_imm), .w_rd(w_rd),
    .w_reg_wen(w_reg_wen), .w_reg_wsel(w_reg_wsel), .w_alu_out(w_alu_out),
    .w_alu_sum(w_alu_sum), .w_csr_value(w_csr_value), .w_mem_type(w_mem_type),
    .w_mem_rdata(w_mem_rdata), .w_exc(w_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        reg_wen;
    logic        exc;
  } exp_t;

  exp_t sb[$];

  // Sets up one M payload; rd and the passthrough fields derive from pc.
  task automatic drive_op(input logic [31:0] pc, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic ren,
                          input logic wen, input logic [2:0] mtype);
    m_valid     = 1'b1;
    m_pc        = pc;
    m_pc4       = pc + 32'd4;
    m_imm       = pc ^ 32'h5A5A_0000;
    m_alu_out   = pc + 32'h100;
    m_csr_value = ~pc;
    m_alu_sum   = addr;
    m_rs2       = rs2;
    m_rd        = pc[6:2];
    m_reg_wen   = ~wen;
    m_reg_wsel  = ren ? 2'b01 : 2'b00;
    m_mem_ren   = ren;
    m_mem_wen   = wen;
    m_mem_type  = mtype;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] rdata,
                          input logic reg_wen, input logic exc);
    exp_t e;
    e.pc = pc; e.rdata = rdata; e.reg_wen = reg_wen; e.exc = exc;
    sb.push_back(e);
  endtask

  task automatic quiet_inputs();
    m_valid = 1'b0; m_mem_ren = 1'b0; m_mem_wen = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; w_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    quiet_inputs();
    m_pc = '0; m_pc4 = '0; m_imm = '0; m_alu_out = '0; m_csr_value = '0;
    m_alu_sum = '0; m_rs2 = '0; m_rd = '0; m_reg_wen = 1'b0; m_reg_wsel = '0;
    m_mem_type = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (w_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_w_valid got %b want 0", w_valid); end
    checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || m_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_comb req %b we %b m_ready %b want 000", bus_req, bus_we, m_ready); end
    checks++; if (w_pc !== '0 || w_mem_rdata !== '0 || w_reg_wen !== 1'b0 || w_exc !== 1'b0) begin errors++; $display("[TB] FAIL rst_payload pc %h rdata %h wen %b exc %b want zeros", w_pc, w_mem_rdata, w_reg_wen, w_exc); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_byte();
    exp_t e;
    @(negedge clk);
    drive_op(32'h0000_0010, 32'h0000_1003, 32'h0, 1'b1, 1'b0, 3'b000);
    bus_gnt = 1'b1;
    push_exp(32'h0000_0010, 32'hFFFF_FF80, 1'b1, 1'b0);
    #1;
    checks++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || m_ready !== 1'b0) begin errors++; $display("[TB] FAIL lb_c0 req %b we %b m_ready %b want 100", bus_req, bus_we, m_ready); end
    checks++; if (bus_addr !== 32'h0000_1000) begin errors++; $display("[TB] FAIL lb_addr got %h want 00001000", bus_addr); end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      bus_gnt = 1'b0;
      #1;
      checks++; if (bus_req !== 1'b0 || m_ready !== 1'b0 || w_valid !== 1'b0) begin errors++; $display("[TB] FAIL lb_wait%0d req %b m_ready %b w_valid %b want 000", c, bus_req, m_ready, w_valid); end
    end
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h8012_3456;
    #1;
    checks++; if (m_ready !== 1'b1 || w_valid !== 1'b0) begin errors++; $display("[TB] FAIL lb_c3 m_ready %b w_valid %b want 10", m_ready, w_valid); end
    @(negedge clk);
    bus_rvalid = 1'b0;
    m_valid    = 1'b0;
    #1;
    checks++;
    if (sb.size() == 0) begin errors++; $display("[TB] FAIL lb_w scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if (w_valid !== 1'b1 || w_pc !== e.pc || w_pc4 !== e.pc + 32'd4 || w_rd !== e.pc[6:2] || w_mem_rdata !== e.rdata || w_reg_wen !== e.reg_wen || w_exc !== e.exc) begin
        errors++; $display("[TB] FAIL lb_w valid %b pc %h/%h rd %h rdata %h/%h wen %b/%b exc %b/%b", w_valid, w_pc, e.pc, w_rd, w_mem_rdata, e.rdata, w_reg_wen, e.reg_wen, w_exc, e.exc);
      end
    end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("[TB] FAIL lb_c4_m_ready got %b want 0", m_ready); end
  endtask

  // Minimum-latency loads exercising each extension flavour.
  task automatic test_load_ext();
    logic [31:0] addrs [5] = '{32'h1002, 32'h1002, 32'h1001, 32'h1000, 32'h1000};
    logic [2:0]  types [5] = '{3'b001, 3'b101, 3'b100, 3'b000, 3'b010};
    logic [31:0] rds   [5] = '{32'h8001_7FFF, 32'h8001_7FFF, 32'h0000_F000, 32'h0000_007F, 32'hDEAD_BEEF};
    logic [31:0] exps  [5] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_00F0, 32'h0000_007F, 32'hDEAD_BEEF};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_op(32'h0000_0020 + 32'(i * 4), addrs[i], 32'h0, 1'b1, 1'b0, types[i]);
      bus_gnt = 1'b1;
      push_exp(32'h0000_0020 + 32'(i * 4), exps[i], 1'b1, 1'b0);
      @(negedge clk);
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = rds[i];
      #1;
      checks++; if (m_ready !== 1'b1) begin errors++; $display("[TB] FAIL ext%0d_m_ready got %b want 1", i, m_ready); end
      @(negedge clk);
      bus_rvalid = 1'b0;
      m_valid    = 1'b0;
      #1;
      checks++;
      if (sb.size() == 0) begin errors++; $display("[TB] FAIL ext%0d scoreboard empty", i); end
      else begin
        e = sb.pop_front();
        if (w_valid !== 1'b1 || w_pc !== e.pc || w_mem_rdata !== e.rdata || w_mem_type !== types[i]) begin
          errors++; $display("[TB] FAIL ext%0d valid %b pc %h/%h rdata %h/%h type %b/%b", i, w_valid, w_pc, e.pc, w_mem_rdata, e.rdata, w_mem_type, types[i]);
        end
      end
    end
  endtask

  task automatic test_store_half();
    exp_t e;
    @(negedge clk);
    drive_op(32'h0000_0040, 32'h0000_2002, 32'h0000_BEEF, 1'b0, 1'b1, 3'b001);
    bus_gnt = 1'b0;
    push_exp(32'h0000_0040, 32'h0, 1'b0, 1'b0);
    #1;
    checks++; if (bus_req !== 1'b1 || m_ready !== 1'b0) begin errors++; $display("[TB] FAIL sh_stall req %b m_ready %b want 10", bus_req, m_ready); end
    @(negedge clk);
    bus_gnt = 1'b1;
    #1;
    checks++; if (bus_addr !== 32'h0000_2000 || bus_bytemask !== 4'b1100) begin errors++; $display("[TB] FAIL sh_addr_mask addr %h mask %b want 00002000 1100", bus_addr, bus_bytemask); end
    checks++; if (bus_wdata !== 32'hBEEF_0000 || bus_we !== 1'b1) begin errors++; $display("[TB] FAIL sh_wdata wdata %h we %b want beef0000 1", bus_wdata, bus_we); end
    @(negedge clk);
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h5555_AAAA;
    #1;
    checks++; if (m_ready !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("[TB] FAIL sh_ack m_ready %b req %b want 10", m_ready, bus_req); end
    @(negedge clk);
    bus_rvalid = 1'b0;
    m_valid    = 1'b0;
    #1;
    checks++;
    if (sb.size() == 0) begin errors++; $display("[TB] FAIL sh_w scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if (w_valid !== 1'b1 || w_pc !== e.pc || w_mem_rdata !== e.rdata || w_reg_wen !== e.reg_wen) begin
        errors++; $display("[TB] FAIL sh_w valid %b pc %h/%h rdata %h/%h wen %b/%b", w_valid, w_pc, e.pc, w_mem_rdata, e.rdata, w_reg_wen, e.reg_wen);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    // ALU op occupies W while writeback is stalled.
    @(negedge clk);
    drive_op(32'h0000_0100, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    w_ready = 1'b0;
    push_exp(32'h0000_0100, 32'h0, 1'b1, 1'b0);
    #1;
    checks++; if (m_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_alu_m_ready got %b want 1", m_ready); end
    @(negedge clk);
    drive_op(32'h0000_0104, 32'h0000_3000, 32'h0, 1'b1, 1'b0, 3'b010);
    bus_gnt = 1'b1;
    #1;
    checks++; if (w_valid !== 1'b1 || bus_req !== 1'b1) begin errors++; $display("[TB] FAIL hold_req w_valid %b req %b want 11", w_valid, bus_req); end
    @(negedge clk);
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hCAFE_F00D;
    push_exp(32'h0000_0104, 32'hCAFE_F00D, 1'b1, 1'b0);
    #1;
    checks++; if (m_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_rvalid_m_ready got %b want 0", m_ready); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus_rvalid = (c == 0);
      bus_rdata  = 32'hDEAD_0000;
      #1;
      checks++; if (m_ready !== 1'b0 || w_valid !== 1'b1 || w_pc !== 32'h0000_0100) begin errors++; $display("[TB] FAIL hold_stall%0d m_ready %b w_valid %b w_pc %h want 0 1 00000100", c, m_ready, w_valid, w_pc); end
    end
    @(negedge clk);
    bus_rvalid = 1'b0;
    w_ready    = 1'b1;
    #1;
    checks++; if (m_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_release_m_ready got %b want 1", m_ready); end
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        @(negedge clk);
        m_valid = 1'b0;
        #1;
      end
      checks++;
      if (sb.size() == 0) begin errors++; $display("[TB] FAIL hold_w%0d scoreboard empty", k); end
      else begin
        e = sb.pop_front();
        if (w_valid !== 1'b1 || w_pc !== e.pc || w_mem_rdata !== e.rdata || w_reg_wen !== e.reg_wen) begin
          errors++; $display("[TB] FAIL hold_w%0d valid %b pc %h/%h rdata %h/%h wen %b/%b", k, w_valid, w_pc, e.pc, w_mem_rdata, e.rdata, w_reg_wen, e.reg_wen);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    w_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i < 5) begin
        drive_op(32'h0000_0200 + 32'(i * 4), 32'(i), 32'h0, 1'b0, 1'b0, 3'b010);
        push_exp(32'h0000_0200 + 32'(i * 4), 32'h0, 1'b1, 1'b0);
      end else begin
        m_valid = 1'b0;
      end
      #1;
      if (i < 5) begin
        checks++; if (m_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b%0d_m_ready got %b want 1", i, m_ready); end
      end
      if (i > 0) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("[TB] FAIL b2b%0d scoreboard empty", i); end
        else begin
          e = sb.pop_front();
          if (w_valid !== 1'b1 || w_pc !== e.pc || w_alu_out !== e.pc + 32'h100 || w_mem_rdata !== e.rdata) begin
            errors++; $display("[TB] FAIL b2b%0d valid %b pc %h/%h alu %h rdata %h/%h", i, w_valid, w_pc, e.pc, w_alu_out, w_mem_rdata, e.rdata);
          end
        end
      end
    end
    @(negedge clk);
    #1;
    checks++; if (w_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain w_valid got %b want 0", w_valid); end
  endtask

  task automatic test_misalign();
    exp_t e;
    @(negedge clk);
    drive_op(32'h0000_0300, 32'h0000_1001, 32'h0, 1'b1, 1'b0, 3'b010);
`ifdef CORE_MEM_MISALIGN_TRAP_EN
    bus_gnt = 1'b0;
    push_exp(32'h0000_0300, 32'h0, 1'b0, 1'b1);
    #1;
    checks++; if (bus_req !== 1'b0 || m_ready !== 1'b1) begin errors++; $display("[TB] FAIL mis_trap req %b m_ready %b want 01", bus_req, m_ready); end
`else
    bus_gnt = 1'b1;
    push_exp(32'h0000_0300, 32'h0011_2233, 1'b1, 1'b0);
    #1;
    checks++; if (bus_req !== 1'b1 || bus_bytemask !== 4'b1110) begin errors++; $display("[TB] FAIL mis_issue req %b mask %b want 1 1110", bus_req, bus_bytemask); end
    @(negedge clk);
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h1122_3344;
    #1;
    checks++; if (m_ready !== 1'b1) begin errors++; $display("[TB] FAIL mis_m_ready got %b want 1", m_ready); end
`endif
    @(negedge clk);
    bus_rvalid = 1'b0;
    m_valid    = 1'b0;
    #1;
    checks++;
    if (sb.size() == 0) begin errors++; $display("[TB] FAIL mis_w scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if (w_valid !== 1'b1 || w_pc !== e.pc || w_mem_rdata !== e.rdata || w_reg_wen !== e.reg_wen || w_exc !== e.exc) begin
        errors++; $display("[TB] FAIL mis_w valid %b pc %h/%h rdata %h/%h wen %b/%b exc %b/%b", w_valid, w_pc, e.pc, w_mem_rdata, e.rdata, w_reg_wen, e.reg_wen, w_exc, e.exc);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge clk);
    drive_op(32'h0000_0400, 32'h0000_4000, 32'h0, 1'b1, 1'b0, 3'b010);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    m_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0 || w_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_in_reset req %b w_valid %b want 00", bus_req, w_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h1234_5678;
    #1;
    checks++; if (m_ready !== 1'b0) begin errors++; $display("[TB] FAIL rmid_late_rvalid m_ready got %b want 0", m_ready); end
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    checks++; if (w_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_w_valid got %b want 0", w_valid); end
    @(negedge clk);
    drive_op(32'h0000_0500, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    push_exp(32'h0000_0500, 32'h0, 1'b1, 1'b0);
    #1;
    checks++; if (m_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_idle_m_ready got %b want 1", m_ready); end
    @(negedge clk);
    m_valid = 1'b0;
    #1;
    checks++;
    if (sb.size() == 0) begin errors++; $display("[TB] FAIL rmid_w scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if (w_valid !== 1'b1 || w_pc !== e.pc || w_mem_rdata !== e.rdata) begin
        errors++; $display("[TB] FAIL rmid_w valid %b pc %h/%h rdata %h/%h", w_valid, w_pc, e.pc, w_mem_rdata, e.rdata);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_load_byte();
    test_load_ext();
    test_store_half();
    test_hold();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
